// File: rtl/icache_refill_ctrl_pkg.sv
// rtl/icache_refill_ctrl_pkg.sv - shared types, constants and helpers for the icache refill controller
//
// Purpose: refill FSM state encoding, default geometry, the line-offset mask
// and the saturating-increment helper used by the statistics counters.
// Ports: none (package).
package icache_refill_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_BEATS  = 2;
  localparam int LINE_W     = DEF_BEATS * DEF_WORD_W;

  // Byte-offset bits inside a 64-bit line; cleared to form the line base.
  localparam logic [2:0] LINE_OFF_MASK = 3'b111;

  // Increment val, holding at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_sat_counter.sv
// rtl/icache_refill_ctrl_sat_counter.sv - saturating event counter
//
// Purpose: counts single-cycle inc pulses, sticking at all-ones.
// Ports:
//   CLK    in   clock, rising edge
//   RESET  in   asynchronous active-high reset, clears count
//   inc    in   count one event this cycle
//   count  out  CNT_W-bit saturating count
module sat_counter
  import icache_refill_ctrl_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [31:0] count_next;

  assign count_next = sat_inc(32'(count), CNT_W);

  // Bits above CNT_W are always zero; fold them away explicitly.
  generate
    if (CNT_W < 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^count_next[31:CNT_W];
    end
  endgenerate

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (inc) begin
      count <= count_next[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - instruction cache miss handler / line refill controller
//
// Purpose: on a cache miss, fetches the aligned BEATS-word line from memory
// one word at a time, assembles it, and writes it to the cache with a
// one-cycle refill strobe while stalling IF. A flush during the fetch lets
// the memory beats finish but drops the line.
// Ports:
//   CLK, RESET             clock (rising edge), asynchronous active-high reset
//   miss_req, miss_addr    level miss request and the missing PC
//   flush                  IF redirect; aborts an in-progress fetch
//   stall                  high while a refill is outstanding (FETCH, FILL)
//   refill_valid/addr/data one-cycle line write to the cache
//   mem_req, mem_addr      per-word memory request (level) and word address
//   mem_ack, mem_rdata     one-cycle word return
//   cnt_refill, cnt_abort  saturating completed / aborted refill counters
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_WORD_W,
  parameter int BEATS  = DEF_BEATS,
  parameter int CNT_W  = 20
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    miss_req,
  input  logic [ADDR_W-1:0]       miss_addr,
  input  logic                    flush,
  output logic                    stall,
  output logic                    refill_valid,
  output logic [ADDR_W-1:0]       refill_addr,
  output logic [BEATS*WORD_W-1:0] refill_data,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ack,
  input  logic [WORD_W-1:0]       mem_rdata,
  output logic [CNT_W-1:0]        cnt_refill,
  output logic [CNT_W-1:0]        cnt_abort
);

  localparam int LINE_BITS = BEATS * WORD_W;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     base_q;
  logic [BEAT_W-1:0]     beat_q;
  logic                  abort_q;
  logic [LINE_BITS-1:0]  line_q, line_d;
  logic                  start, last_beat, abort_d;
  logic                  inc_refill, inc_abort;

  assign start     = (state_q == ST_IDLE) && miss_req && !flush;
  assign last_beat = (beat_q == LAST_BEAT);
  // A flush in the final-ack cycle must still count as an abort.
  assign abort_d   = abort_q | flush;
  assign mem_addr  = base_q + (ADDR_W'(beat_q) << 2);

  always_comb begin
    line_d = line_q;
    line_d[int'(beat_q)*WORD_W +: WORD_W] = mem_rdata;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    mem_req      = 1'b0;
    refill_valid = 1'b0;
    inc_refill   = 1'b0;
    inc_abort    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack && last_beat) begin
          if (abort_d) begin
            state_d   = ST_IDLE;
            inc_abort = 1'b1;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        stall        = 1'b1;
        refill_valid = 1'b1;
        inc_refill   = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // refill_data/refill_addr only load on a good final beat, so they stay
  // stable through FILL and hold afterwards; aborted lines never reach them.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      base_q      <= '0;
      beat_q      <= '0;
      abort_q     <= 1'b0;
      line_q      <= '0;
      refill_addr <= '0;
      refill_data <= '0;
    end else if (start) begin
      base_q  <= miss_addr & ~ADDR_W'(LINE_OFF_MASK);
      beat_q  <= '0;
      abort_q <= 1'b0;
    end else if (state_q == ST_FETCH) begin
      abort_q <= abort_d;
      if (mem_ack) begin
        line_q <= line_d;
        beat_q <= beat_q + 1'b1;
        if (last_beat && !abort_d) begin
          refill_data <= line_d;
          refill_addr <= base_q;
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt_refill (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (inc_refill),
    .count (cnt_refill)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_abort (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (inc_abort),
    .count (cnt_abort)
  );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - directed self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;
  import icache_refill_ctrl_pkg::*;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              miss_req = 1'b0;
  logic [31:0]       miss_addr = '0;
  logic              flush = 1'b0;
  logic              mem_ack = 1'b0;
  logic [31:0]       mem_rdata = '0;
  logic              stall, refill_valid, mem_req;
  logic [31:0]       refill_addr, mem_addr;
  logic [LINE_W-1:0] refill_data;
  logic [19:0]       cnt_refill, cnt_abort;
  logic              unused_s_stall, unused_s_valid, unused_s_req;
  logic [31:0]       unused_s_raddr, unused_s_maddr;
  logic [63:0]       unused_s_rdata;
  logic [1:0]        cnt_refill_s, cnt_abort_s;

  always #5 CLK = ~CLK;

  icache_refill_ctrl dut (
    .CLK(CLK), .RESET(RESET), .miss_req(miss_req), .miss_addr(miss_addr), .flush(flush),
    .stall(stall), .refill_valid(refill_valid), .refill_addr(refill_addr), .refill_data(refill_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .cnt_refill(cnt_refill), .cnt_abort(cnt_abort)
  );

  // Narrow-counter copy so saturation is reachable in a few refills.
  icache_refill_ctrl #(.CNT_W(2)) dut_sat (
    .CLK(CLK), .RESET(RESET), .miss_req(miss_req), .miss_addr(miss_addr), .flush(flush),
    .stall(unused_s_stall), .refill_valid(unused_s_valid), .refill_addr(unused_s_raddr),
    .refill_data(unused_s_rdata), .mem_req(unused_s_req), .mem_addr(unused_s_maddr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .cnt_refill(cnt_refill_s), .cnt_abort(cnt_abort_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          mem_lat = 0;
  bit          ack_force = 0;
  bit          trk_valid = 0;
  logic [31:0] trk_addr = '0;
  int          wcnt = 0;

  int          obs_stall, obs_valid, obs_ack_n, obs_valid_cyc, obs_last_ack_cyc;
  int          obs_req_gap, obs_addr_jump;
  logic        obs_cyc1_stall;
  bit          obs_timeout;
  logic [31:0] obs_ack_addr [4];
  logic [31:0] obs_raddr;
  logic [63:0] obs_rdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h1111_1111;
    if (a == 32'h44) return 32'h2222_2222;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Advance to the next falling edge and drive the memory response for it.
  task automatic tick();
    @(negedge CLK);
    if (ack_force) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
    end else if (mem_req) begin
      if (!trk_valid || mem_addr !== trk_addr) begin
        trk_valid = 1;
        trk_addr  = mem_addr;
        wcnt      = 0;
      end else begin
        wcnt++;
      end
      mem_ack   = (wcnt == mem_lat);
      mem_rdata = mem_ack ? mem_word(mem_addr) : 32'h0;
      if (mem_ack) trk_valid = 0;
    end else begin
      trk_valid = 0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
    end
  endtask

  // Runs one miss to completion and records what the DUT did.
  task automatic run_miss(input logic [31:0] addr, input int lat, input int flush_cyc);
    int cyc;
    logic prev_req, prev_ack;
    logic [31:0] prev_addr;
    obs_stall = 0; obs_valid = 0; obs_ack_n = 0; obs_valid_cyc = -1; obs_last_ack_cyc = -1;
    obs_req_gap = 0; obs_addr_jump = 0; obs_cyc1_stall = 1'b0; obs_timeout = 0;
    obs_raddr = '0; obs_rdata = '0;
    mem_lat = lat; miss_addr = addr; miss_req = 1'b1; flush = 1'b0;
    cyc = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    while (1) begin
      tick();
      cyc++;
      flush = (cyc == flush_cyc);
      if (flush) miss_req = 1'b0;
      if (cyc == 1) obs_cyc1_stall = stall;
      if (stall) obs_stall++;
      if (stall && !refill_valid && !mem_req) obs_req_gap++;
      if (mem_req && prev_req && !prev_ack && mem_addr !== prev_addr) obs_addr_jump++;
      if (mem_ack) begin
        if (obs_ack_n < 4) obs_ack_addr[obs_ack_n] = mem_addr;
        obs_ack_n++;
        obs_last_ack_cyc = cyc;
      end
      if (refill_valid) begin
        obs_valid++;
        obs_raddr = refill_addr;
        obs_rdata = refill_data;
        obs_valid_cyc = cyc;
        miss_req = 1'b0;
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
      if (cyc > 1 && !stall) break;
      if (cyc >= 200) begin
        obs_timeout = 1;
        break;
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    n_tests++; if (refill_valid !== 1'b0) begin n_fail++; $display("FAIL reset_refill_valid got %b want 0", refill_valid); end
    n_tests++; if (refill_data !== 64'h0) begin n_fail++; $display("FAIL reset_refill_data got %h want 0", refill_data); end
    n_tests++; if (refill_addr !== 32'h0) begin n_fail++; $display("FAIL reset_refill_addr got %h want 0", refill_addr); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_tests++; if (cnt_refill !== 20'h0 || cnt_abort !== 20'h0) begin n_fail++; $display("FAIL reset_counters got %h/%h want 0/0", cnt_refill, cnt_abort); end
    RESET = 1'b0;
  endtask

  task automatic test_basic();
    run_miss(32'h44, 0, 0);
    n_tests++; if (obs_timeout !== 0) begin n_fail++; $display("FAIL basic_timeout got %0d want 0", obs_timeout); end
    n_tests++; if (obs_ack_n !== 2) begin n_fail++; $display("FAIL basic_beats got %0d want 2", obs_ack_n); end
    n_tests++; if (obs_ack_addr[0] !== 32'h40 || obs_ack_addr[1] !== 32'h44) begin n_fail++; $display("FAIL basic_mem_addr got %h,%h want 40,44", obs_ack_addr[0], obs_ack_addr[1]); end
    n_tests++; if (obs_valid !== 1) begin n_fail++; $display("FAIL basic_valid_cycles got %0d want 1", obs_valid); end
    n_tests++; if (obs_valid_cyc !== 3) begin n_fail++; $display("FAIL basic_latency got %0d want 3", obs_valid_cyc); end
    n_tests++; if (obs_raddr !== 32'h40) begin n_fail++; $display("FAIL basic_refill_addr got %h want 40", obs_raddr); end
    n_tests++; if (obs_rdata !== 64'h2222_2222_1111_1111) begin n_fail++; $display("FAIL basic_refill_data got %h want 2222222211111111", obs_rdata); end
    n_tests++; if (obs_stall !== 3) begin n_fail++; $display("FAIL basic_stall_cycles got %0d want 3", obs_stall); end
    n_tests++; if (cnt_refill !== 20'd1) begin n_fail++; $display("FAIL basic_cnt_refill got %0d want 1", cnt_refill); end
  endtask

  task automatic test_slow_memory();
    run_miss(32'h44, 5, 0);
    n_tests++; if (obs_timeout !== 0) begin n_fail++; $display("FAIL slow_timeout got %0d want 0", obs_timeout); end
    n_tests++; if (obs_req_gap !== 0) begin n_fail++; $display("FAIL slow_req_gap got %0d want 0", obs_req_gap); end
    n_tests++; if (obs_addr_jump !== 0) begin n_fail++; $display("FAIL slow_addr_unstable got %0d want 0", obs_addr_jump); end
    n_tests++; if (obs_ack_n !== 2) begin n_fail++; $display("FAIL slow_beats got %0d want 2", obs_ack_n); end
    n_tests++; if (obs_last_ack_cyc !== 12 || obs_valid_cyc !== 13) begin n_fail++; $display("FAIL slow_valid_timing got ack %0d valid %0d want 12/13", obs_last_ack_cyc, obs_valid_cyc); end
    n_tests++; if (obs_stall !== 13) begin n_fail++; $display("FAIL slow_stall_cycles got %0d want 13", obs_stall); end
    n_tests++; if (obs_rdata !== 64'h2222_2222_1111_1111) begin n_fail++; $display("FAIL slow_refill_data got %h want 2222222211111111", obs_rdata); end
    n_tests++; if (cnt_refill !== 20'd2) begin n_fail++; $display("FAIL slow_cnt_refill got %0d want 2", cnt_refill); end
  endtask

  task automatic test_flush_mid_fetch();
    run_miss(32'h44, 2, 4);
    n_tests++; if (obs_ack_n !== 2) begin n_fail++; $display("FAIL flush_mid_beats got %0d want 2", obs_ack_n); end
    n_tests++; if (obs_valid !== 0) begin n_fail++; $display("FAIL flush_mid_refill_valid got %0d want 0", obs_valid); end
    n_tests++; if (obs_stall !== 6) begin n_fail++; $display("FAIL flush_mid_stall_cycles got %0d want 6", obs_stall); end
    n_tests++; if (cnt_abort !== 20'd1 || cnt_refill !== 20'd2) begin n_fail++; $display("FAIL flush_mid_counters got %0d/%0d want 1/2", cnt_abort, cnt_refill); end
    n_tests++; if (refill_data !== 64'h2222_2222_1111_1111) begin n_fail++; $display("FAIL flush_mid_data_held got %h want 2222222211111111", refill_data); end
  endtask

  task automatic test_flush_final_ack();
    run_miss(32'h1234, 0, 2);
    n_tests++; if (obs_valid !== 0) begin n_fail++; $display("FAIL flush_last_refill_valid got %0d want 0", obs_valid); end
    n_tests++; if (obs_stall !== 2) begin n_fail++; $display("FAIL flush_last_stall_cycles got %0d want 2", obs_stall); end
    n_tests++; if (cnt_abort !== 20'd2 || cnt_refill !== 20'd2) begin n_fail++; $display("FAIL flush_last_counters got %0d/%0d want 2/2", cnt_abort, cnt_refill); end
    n_tests++; if (refill_addr !== 32'h40) begin n_fail++; $display("FAIL flush_last_addr_held got %h want 40", refill_addr); end
  endtask

  task automatic test_flush_in_fill();
    run_miss(32'h2A4, 0, 3);
    n_tests++; if (obs_valid !== 1) begin n_fail++; $display("FAIL flush_fill_refill_valid got %0d want 1", obs_valid); end
    n_tests++; if (obs_raddr !== 32'h2A0) begin n_fail++; $display("FAIL flush_fill_refill_addr got %h want 2a0", obs_raddr); end
    n_tests++; if (obs_rdata !== 64'h02A4_FD5B_02A0_FD5F) begin n_fail++; $display("FAIL flush_fill_refill_data got %h want 02a4fd5b02a0fd5f", obs_rdata); end
    n_tests++; if (cnt_refill !== 20'd3 || cnt_abort !== 20'd2) begin n_fail++; $display("FAIL flush_fill_counters got %0d/%0d want 3/2", cnt_refill, cnt_abort); end
  endtask

  task automatic test_idle_ignore();
    miss_addr = 32'h80; miss_req = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (stall !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_miss_flush got stall %b req %b want 0/0", stall, mem_req); end
    end
    miss_req = 1'b0; flush = 1'b0; ack_force = 1;
    tick();
    ack_force = 0;
    tick(); tick();
    n_tests++; if (stall !== 1'b0 || mem_req !== 1'b0 || refill_valid !== 1'b0) begin n_fail++; $display("FAIL idle_spurious_ack got stall %b req %b valid %b want 0/0/0", stall, mem_req, refill_valid); end
    n_tests++; if (cnt_refill !== 20'd3 || cnt_abort !== 20'd2) begin n_fail++; $display("FAIL idle_counters got %0d/%0d want 3/2", cnt_refill, cnt_abort); end
  endtask

  task automatic test_back_to_back();
    run_miss(32'h44, 0, 0);
    run_miss(32'h100C, 0, 0);
    n_tests++; if (obs_cyc1_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_no_gap got %b want 1", obs_cyc1_stall); end
    n_tests++; if (obs_raddr !== 32'h1008) begin n_fail++; $display("FAIL b2b_refill_addr got %h want 1008", obs_raddr); end
    n_tests++; if (obs_rdata !== 64'h100C_EFF3_1008_EFF7) begin n_fail++; $display("FAIL b2b_refill_data got %h want 100ceff31008eff7", obs_rdata); end
    n_tests++; if (cnt_refill !== 20'd5) begin n_fail++; $display("FAIL b2b_cnt_refill got %0d want 5", cnt_refill); end
    tick(); tick();
    n_tests++; if (refill_data !== 64'h100C_EFF3_1008_EFF7 || refill_addr !== 32'h1008) begin n_fail++; $display("FAIL b2b_hold got %h @%h want 100ceff31008eff7 @1008", refill_data, refill_addr); end
  endtask

  task automatic test_async_reset();
    miss_addr = 32'h44; miss_req = 1'b1; mem_lat = 0;
    tick();
    n_tests++; if (mem_req !== 1'b1 || mem_ack !== 1'b1) begin n_fail++; $display("FAIL areset_setup got req %b ack %b want 1/1", mem_req, mem_ack); end
    @(posedge CLK);
    #2;
    RESET = 1'b1; mem_ack = 1'b0; miss_req = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL areset_immediate got req %b stall %b want 0/0", mem_req, stall); end
    n_tests++; if (cnt_refill !== 20'h0 || cnt_abort !== 20'h0) begin n_fail++; $display("FAIL areset_counters got %0d/%0d want 0/0", cnt_refill, cnt_abort); end
    tick();
    RESET = 1'b0; ack_force = 1;
    tick();
    ack_force = 0;
    tick();
    n_tests++; if (mem_req !== 1'b0 || stall !== 1'b0 || refill_valid !== 1'b0) begin n_fail++; $display("FAIL areset_late_ack got req %b stall %b valid %b want 0/0/0", mem_req, stall, refill_valid); end
    run_miss(32'h44, 0, 0);
    n_tests++; if (obs_rdata !== 64'h2222_2222_1111_1111 || obs_raddr !== 32'h40) begin n_fail++; $display("FAIL areset_refill got %h @%h want 2222222211111111 @40", obs_rdata, obs_raddr); end
    n_tests++; if (cnt_refill !== 20'd1) begin n_fail++; $display("FAIL areset_cnt_refill got %0d want 1", cnt_refill); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_s;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      run_miss(32'h44, 0, 0);
      exp_s = (i > 3) ? 2'd3 : 2'(i);
      n_tests++; if (cnt_refill_s !== exp_s) begin n_fail++; $display("FAIL sat_refill_%0d got %0d want %0d", i, cnt_refill_s, exp_s); end
      n_tests++; if (cnt_refill !== 20'(i)) begin n_fail++; $display("FAIL sat_wide_refill_%0d got %0d want %0d", i, cnt_refill, i); end
    end
    for (int i = 1; i <= 4; i++) begin
      run_miss(32'h44, 0, 2);
      exp_s = (i > 3) ? 2'd3 : 2'(i);
      n_tests++; if (cnt_abort_s !== exp_s) begin n_fail++; $display("FAIL sat_abort_%0d got %0d want %0d", i, cnt_abort_s, exp_s); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slow_memory();
    test_flush_mid_fetch();
    test_flush_final_ack();
    test_flush_in_fill();
    test_idle_ignore();
    test_back_to_back();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Miss handler between the 2-way multiword instruction cache and main memory.
- On a cache miss it fetches the aligned two-word block from memory over a per-word req/ack handshake and assembles it into a 64-bit line.
- Delivers the line to the cache with a one-cycle refill strobe and holds the IF stage stalled until then.
- Aborts cleanly on an IF flush (jump/branch redirect) without corrupting the cache.

Parameters:
- ADDR_W, 32, byte address width
- WORD_W, 32, memory word width
- BEATS, 2, words per cache line; line width = BEATS*WORD_W
- CNT_W, 20, width of the saturating statistics counters

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- miss_req  in  1  cache miss for miss_addr; level, held by the cache while it is stalled
- miss_addr  in  ADDR_W  PC that missed
- flush  in  1  IF flush; aborts a pending refill
- stall  out  1  freeze PC and IF/ID while a refill is outstanding
- refill_valid  out  1  one-cycle strobe: cache writes refill_data into the line for refill_addr
- refill_addr  out  ADDR_W  line-aligned address, low 3 bits always 0
- refill_data  out  BEATS*WORD_W  assembled line; word k at bits [k*WORD_W +: WORD_W]
- mem_req  out  1  memory word request, level
- mem_addr  out  ADDR_W  word address of the current beat
- mem_ack  in  1  one-cycle pulse: mem_rdata is valid for mem_addr
- mem_rdata  in  WORD_W  returned word
- cnt_refill  out  CNT_W  completed refills, saturating
- cnt_abort  out  CNT_W  aborted refills, saturating

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE; all outputs 0, including stall, mem_req, refill_valid, refill_data, refill_addr and both counters.
  - Reset mid-transaction drops mem_req at once; any later mem_ack is ignored in IDLE.
- States: IDLE, FETCH, FILL.
- IDLE:
  - On miss_req=1 and flush=0: latch base = {miss_addr[ADDR_W-1:3], 3'b000}, clear the beat index and abort flag, go to FETCH.
  - miss_req together with flush: ignored, stay in IDLE.
  - mem_ack in IDLE is ignored.
- FETCH:
  - mem_req=1; mem_addr = base + 4*beat.
  - Each cycle with mem_ack=1 stores mem_rdata into word slot beat and increments beat.
  - mem_addr advances the cycle after each ack. mem_req stays high between beats and drops the cycle after the final ack.
  - On the final ack (beat == BEATS-1): go to FILL if the abort flag is clear, otherwise go to IDLE and increment cnt_abort.
  - flush=1 in any FETCH cycle, including the final-ack cycle, sets the abort flag.
  - Outstanding beats are always completed; the memory transaction is never cut short.
- FILL:
  - refill_valid=1 for exactly one cycle, with refill_addr=base and the assembled refill_data; increment cnt_refill; return to IDLE.
  - flush in FILL does not suppress the write, because the line data is valid.
- stall = 1 in FETCH and FILL, 0 in IDLE. The cache retries the PC the cycle after FILL and hits.
- Back-to-back misses: a miss_req seen in IDLE right after FILL starts a new refill. No extra idle cycle is required.
- Latency, with memory acking each beat one cycle after it is presented:
  - Edge 0: miss_req sampled, enter FETCH.
  - Acks arrive in cycles 1 and 2.
  - refill_valid in cycle 3.
  - stall high for cycles 1-3.
- Counters saturate at all-ones and do not wrap.
- refill_data and refill_addr hold their last values outside FILL.

Decomposition:
- Shared package: state enum (IDLE/FETCH/FILL), LINE_W = BEATS*WORD_W, the line-alignment mask constant, and the saturating-increment function.
- One natural sub-module, sat_counter (CNT_W, inc, RESET → count), instantiated twice for cnt_refill and cnt_abort.
- The FSM and line assembly stay in the top module.

Test Plan:
- Basic refill:
  - Stimulus: miss_addr=0x0000_0044, memory returns 0x1111_1111 @0x40 and 0x2222_2222 @0x44 with 1-cycle ack latency.
  - Required: mem_addr 0x40 then 0x44; refill_valid for one cycle with refill_addr=0x40 and refill_data=0x2222_2222_1111_1111; stall high for exactly 3 cycles; cnt_refill=1.
- Slow memory:
  - Stimulus: same as basic refill, but each ack arrives 5 cycles after the request.
  - Required: mem_req held continuously across both beats; mem_addr stable while waiting; refill_valid 1 cycle after the second ack; no extra beats requested.
- Flush mid-fetch:
  - Stimulus: flush pulses between beat 0 and beat 1.
  - Required: both beats still consumed; refill_valid never asserted; return to IDLE; cnt_abort=1; cnt_refill unchanged.
- Flush coincident with miss in IDLE, and spurious ack in IDLE:
  - Required: no mem_req, state stays IDLE, stall=0.
- Async reset mid-FETCH:
  - Stimulus: assert RESET after beat 0 acks, between clock edges.
  - Required: mem_req, stall and counters go to 0 immediately; a following mem_ack is ignored; the next miss refills correctly.
- Counter saturation:
  - Stimulus: preload or force the counter to 2^20-2, then run 3 refills.
  - Required: cnt_refill=0xFFFFF and stays there.
